// File: rtl/bus_xbar_rr.sv
// bus_xbar_rr: NrHosts x NrDevices system-bus crossbar with a round-robin arbiter per device.
//
// Each host request is decoded against per-device base/mask pairs. The lowest matching index
// wins, and an address that matches no device goes to a per-host decode-error responder.
// A host may have up to MaxOutstanding transactions in flight, all to a single target. That
// rule keeps its responses in order without reorder buffers. Each device keeps a FIFO of
// granted host IDs so that its responses are routed back in grant order.
//
// Ports:
//   clk_sys_i, rst_sys_ni         system clock, asynchronous active-low reset
//   host_req/gnt/addr/we/be/wdata request channel per host (flattened, host h at slice h)
//   host_rvalid/rdata/err         response channel per host (rdata is zero when rvalid is low)
//   device_req/addr/we/be/wdata   muxed request channel per device, device_gnt_i accepts
//   device_rvalid/rdata/err       response channel per device
//   cfg_device_addr_base/mask_i   address decode configuration per device
//   host_stall_cnt_o              saturating per-host stall counters (BUS_XBAR_PERF_EN only)
//
// Optional feature: define BUS_XBAR_PERF_EN to add host_stall_cnt_o and its counters.
module bus_xbar_rr #(
  parameter int unsigned NrHosts        = 2,
  parameter int unsigned NrDevices      = 8,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                              clk_sys_i,
  input  logic                              rst_sys_ni,
  input  logic [NrHosts-1:0]                host_req_i,
  output logic [NrHosts-1:0]                host_gnt_o,
  input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
  input  logic [NrHosts-1:0]                host_we_i,
  input  logic [NrHosts*DataWidth/8-1:0]    host_be_i,
  input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
  output logic [NrHosts-1:0]                host_rvalid_o,
  output logic [NrHosts*DataWidth-1:0]      host_rdata_o,
  output logic [NrHosts-1:0]                host_err_o,
  output logic [NrDevices-1:0]              device_req_o,
  input  logic [NrDevices-1:0]              device_gnt_i,
  output logic [NrDevices*AddressWidth-1:0] device_addr_o,
  output logic [NrDevices-1:0]              device_we_o,
  output logic [NrDevices*DataWidth/8-1:0]  device_be_o,
  output logic [NrDevices*DataWidth-1:0]    device_wdata_o,
  input  logic [NrDevices-1:0]              device_rvalid_i,
  input  logic [NrDevices*DataWidth-1:0]    device_rdata_i,
  input  logic [NrDevices-1:0]              device_err_i,
  input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_base_i,
  input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_mask_i
`ifdef BUS_XBAR_PERF_EN
  ,
  output logic [NrHosts*32-1:0]             host_stall_cnt_o
`endif
);

  localparam int unsigned BeWidth = DataWidth / 8;
  localparam int unsigned HostIdW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int unsigned DevIdW  = $clog2(NrDevices + 1);
  localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [DevIdW-1:0] ErrDev = DevIdW'(NrDevices);

  logic [NrHosts-1:0][DevIdW-1:0]   tgt, last_dev_q;
  logic [NrHosts-1:0][CntW-1:0]     cnt_q;
  logic [NrHosts-1:0]               elig, fifo_ok, err_pend_q;
  logic [NrDevices-1:0][HostIdW-1:0] rr_q, win_id, head_id;
  logic [NrDevices-1:0]             win_vld, dev_gnt, fifo_full, fifo_empty, pop;
  logic [NrDevices-1:0][MaxOutstanding-1:0][HostIdW-1:0] fifo_q;
  logic [NrDevices-1:0][PtrW-1:0]   wptr_q, rptr_q;
  logic [NrDevices-1:0][CntW-1:0]   fcnt_q;
  logic [HostIdW-1:0]               arb_idx;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Address decode; iterate downwards so the lowest matching index wins.
  always_comb begin
    tgt = '0;
    for (int h = 0; h < NrHosts; h++) begin
      tgt[h] = ErrDev;
      for (int d = NrDevices - 1; d >= 0; d--) begin
        if ((host_addr_i[h*AddressWidth +: AddressWidth] &
             cfg_device_addr_mask_i[d*AddressWidth +: AddressWidth]) ==
            cfg_device_addr_base_i[d*AddressWidth +: AddressWidth]) begin
          tgt[h] = DevIdW'(d);
        end
      end
    end
  end

  always_comb begin
    fifo_full  = '0;
    fifo_empty = '0;
    head_id    = '0;
    pop        = '0;
    for (int d = 0; d < NrDevices; d++) begin
      fifo_full[d]  = (fcnt_q[d] == CntW'(MaxOutstanding));
      fifo_empty[d] = (fcnt_q[d] == '0);
      head_id[d]    = fifo_q[d][rptr_q[d]];
      // Responses with nothing outstanding are dropped.
      pop[d]        = device_rvalid_i[d] & ~fifo_empty[d];
    end
  end

  // Eligibility: outstanding limit, single-target rule and room in the target's ID FIFO.
  always_comb begin
    fifo_ok = '1;
    elig    = '0;
    for (int h = 0; h < NrHosts; h++) begin
      for (int d = 0; d < NrDevices; d++) begin
        if (tgt[h] == DevIdW'(d) && fifo_full[d]) fifo_ok[h] = 1'b0;
      end
      elig[h] = host_req_i[h] & (cnt_q[h] < CntW'(MaxOutstanding)) &
                ((cnt_q[h] == '0) | (last_dev_q[h] == tgt[h])) & fifo_ok[h];
    end
  end

  // Round-robin search per device, starting one past the last winner.
  always_comb begin
    win_vld = '0;
    win_id  = '0;
    arb_idx = '0;
    for (int d = 0; d < NrDevices; d++) begin
      for (int i = 0; i < NrHosts; i++) begin
        arb_idx = HostIdW'((32'(rr_q[d]) + 32'(i) + 32'd1) % NrHosts);
        if (!win_vld[d] && elig[arb_idx] && tgt[arb_idx] == DevIdW'(d)) begin
          win_vld[d] = 1'b1;
          win_id[d]  = arb_idx;
        end
      end
    end
  end

  assign dev_gnt = win_vld & device_gnt_i;

  always_comb begin
    device_req_o   = win_vld;
    device_addr_o  = '0;
    device_we_o    = '0;
    device_be_o    = '0;
    device_wdata_o = '0;
    for (int d = 0; d < NrDevices; d++) begin
      for (int h = 0; h < NrHosts; h++) begin
        if (win_vld[d] && win_id[d] == HostIdW'(h)) begin
          device_addr_o[d*AddressWidth +: AddressWidth] = host_addr_i[h*AddressWidth +: AddressWidth];
          device_we_o[d]                                = host_we_i[h];
          device_be_o[d*BeWidth +: BeWidth]             = host_be_i[h*BeWidth +: BeWidth];
          device_wdata_o[d*DataWidth +: DataWidth]      = host_wdata_i[h*DataWidth +: DataWidth];
        end
      end
    end
  end

  // Single-target rule guarantees at most one response source per host per cycle.
  always_comb begin
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    host_rdata_o  = '0;
    host_err_o    = '0;
    for (int h = 0; h < NrHosts; h++) begin
      host_gnt_o[h] = elig[h] & (tgt[h] == ErrDev);
      if (err_pend_q[h]) begin
        host_rvalid_o[h] = 1'b1;
        host_err_o[h]    = 1'b1;
      end
      for (int d = 0; d < NrDevices; d++) begin
        if (dev_gnt[d] && win_id[d] == HostIdW'(h)) host_gnt_o[h] = 1'b1;
        if (pop[d] && head_id[d] == HostIdW'(h)) begin
          host_rvalid_o[h]                         = 1'b1;
          host_rdata_o[h*DataWidth +: DataWidth]   = device_rdata_i[d*DataWidth +: DataWidth];
          host_err_o[h]                            = device_err_i[d];
        end
      end
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      cnt_q      <= '0;
      last_dev_q <= '0;
      err_pend_q <= '0;
    end else begin
      for (int h = 0; h < NrHosts; h++) begin
        err_pend_q[h] <= host_gnt_o[h] & (tgt[h] == ErrDev);
        if (host_gnt_o[h]) last_dev_q[h] <= tgt[h];
        case ({host_gnt_o[h], host_rvalid_o[h]})
          2'b10:   cnt_q[h] <= cnt_q[h] + CntW'(1);
          2'b01:   cnt_q[h] <= cnt_q[h] - CntW'(1);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      fifo_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
      for (int d = 0; d < NrDevices; d++) rr_q[d] <= HostIdW'(NrHosts - 1);
    end else begin
      for (int d = 0; d < NrDevices; d++) begin
        if (dev_gnt[d]) begin
          fifo_q[d][wptr_q[d]] <= win_id[d];
          wptr_q[d]            <= ptr_inc(wptr_q[d]);
          rr_q[d]              <= win_id[d];
        end
        if (pop[d]) rptr_q[d] <= ptr_inc(rptr_q[d]);
        case ({dev_gnt[d], pop[d]})
          2'b10:   fcnt_q[d] <= fcnt_q[d] + CntW'(1);
          2'b01:   fcnt_q[d] <= fcnt_q[d] - CntW'(1);
          default: ;
        endcase
      end
    end
  end

`ifdef BUS_XBAR_PERF_EN
  logic [NrHosts-1:0][31:0] stall_q;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      stall_q <= '0;
    end else begin
      for (int h = 0; h < NrHosts; h++) begin
        if (host_req_i[h] && !host_gnt_o[h] && stall_q[h] != 32'hFFFF_FFFF) begin
          stall_q[h] <= stall_q[h] + 32'd1;
        end
      end
    end
  end

  assign host_stall_cnt_o = stall_q;
`endif

`ifndef SYNTHESIS
  always @(posedge clk_sys_i) begin
    if (rst_sys_ni) begin
      for (int d = 0; d < NrDevices; d++) begin
        assert (!(device_rvalid_i[d] && fifo_empty[d]))
          else $warning("device %0d rvalid with no outstanding request, dropped", d);
      end
    end
  end
`endif

endmodule
